// File: rtl/te_branch_map.sv
// E-Trace branch map accumulator: records taken/not-taken outcomes of retired branches.
// Optional build macro TE_BRANCH_MAP_OVERFLOW_EN adds a sticky overflow_o flag.
module te_branch_map #(
    parameter int unsigned NR_BRANCHES = 31,
    parameter int unsigned ITYPE_LEN   = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // valid_i qualifies itype_i for one cycle; there is no ready, so every valid
    // event is consumed in the cycle it is presented (or dropped when full).
    input  logic                   valid_i,
    input  logic [ITYPE_LEN-1:0]   itype_i,
    input  logic                   flush_i,
    output logic [NR_BRANCHES-1:0] map_o,
    output logic [4:0]             branches_o,
    output logic                   full_o,
    output logic                   empty_o
`ifdef TE_BRANCH_MAP_OVERFLOW_EN
    ,
    output logic                   overflow_o
`endif
);

    localparam logic [ITYPE_LEN-1:0] ITYPE_NOT_TAKEN = ITYPE_LEN'(4);
    localparam logic [ITYPE_LEN-1:0] ITYPE_TAKEN     = ITYPE_LEN'(5);
    localparam logic [4:0]           COUNT_MAX       = 5'(NR_BRANCHES);

    logic [NR_BRANCHES-1:0] map_q, map_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   branch_ev;
    logic                   not_taken;
    logic                   full;
    logic                   drop;

    assign branch_ev = valid_i && ((itype_i == ITYPE_NOT_TAKEN) || (itype_i == ITYPE_TAKEN));
    assign not_taken = (itype_i == ITYPE_NOT_TAKEN);
    assign full      = (cnt_q == COUNT_MAX);
    assign drop      = branch_ev && !flush_i && full;

    always_comb begin
        map_d = map_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            // The emitter sampled the current map, so a same-cycle branch starts the new one.
            map_d = '0;
            cnt_d = '0;
            if (branch_ev) begin
                map_d[0] = not_taken;
                cnt_d    = 5'd1;
            end
        end else if (branch_ev && !full) begin
            for (int k = 0; k < int'(NR_BRANCHES); k++) begin
                if (cnt_q == 5'(k)) begin
                    map_d[k] = not_taken;
                end
            end
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q <= '0;
            cnt_q <= '0;
        end else begin
            map_q <= map_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef TE_BRANCH_MAP_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    assign map_o      = map_q;
    assign branches_o = cnt_q;
    assign full_o     = full;
    assign empty_o    = (cnt_q == 5'd0);

endmodule

// File: tb/tb_te_branch_map.sv
// Bench for te_branch_map: queue-based outcome model compared every cycle, plus literal checks.
// Works with or without TE_BRANCH_MAP_OVERFLOW_EN defined.
module tb_te_branch_map;

    localparam int NB = 31;
    localparam int IL = 3;

    logic          clk;
    logic          rst_n;
    logic          valid;
    logic [IL-1:0] itype;
    logic          flush;
    logic [NB-1:0] map;
    logic [4:0]    branches;
    logic          full;
    logic          empty;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;

    // Behavioural model: list of recorded outcomes (1 = not taken) and a sticky overflow flag.
    bit   mq[$];
    logic m_ovf = 1'b0;

    te_branch_map #(.NR_BRANCHES(NB), .ITYPE_LEN(IL)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid),
        .itype_i    (itype),
        .flush_i    (flush),
        .map_o      (map),
        .branches_o (branches),
        .full_o     (full),
        .empty_o    (empty)
`ifdef TE_BRANCH_MAP_OVERFLOW_EN
        ,
        .overflow_o (overflow)
`endif
    );

`ifndef TE_BRANCH_MAP_OVERFLOW_EN
    assign overflow = 1'b0;
`endif

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] model_map();
        logic [NB-1:0] m = '0;
        foreach (mq[i]) m[i] = mq[i];
        return m;
    endfunction

    function automatic void model_step(input logic v, input logic [IL-1:0] it, input logic fl);
        bit ev = v && (it == 3'd4 || it == 3'd5);
        if (fl) begin
            mq.delete();
            if (ev) mq.push_back(it == 3'd4);
        end else if (ev) begin
            if (mq.size() < NB) mq.push_back(it == 3'd4);
            else m_ovf = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
    endfunction

    // Driver: one cycle of stimulus, inputs return to idle just after the edge.
    task automatic drive(input logic v, input logic [IL-1:0] it, input logic fl);
        @(negedge clk);
        valid = v;
        itype = it;
        flush = fl;
        @(posedge clk);
        model_step(v, it, fl);
        #1;
        valid = 1'b0;
        flush = 1'b0;
        itype = '0;
    endtask

    // Scoreboard compare process
    always @(negedge clk) begin
        if (started) begin
            chk("map", 32'(map), 32'(model_map()));
            chk("branches", 32'(branches), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == NB));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
`ifdef TE_BRANCH_MAP_OVERFLOW_EN
            chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
        end
    end

    initial begin
        valid = 1'b0;
        itype = '0;
        flush = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_map", 32'(map), 32'h0);
        chk("reset_branches", 32'(branches), 32'h0);
        chk("reset_empty", 32'(empty), 32'h1);
        chk("reset_full", 32'(full), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        started = 1'b1;

        // Pattern 5,4,4,5
        drive(1, 3'd5, 0);
        drive(1, 3'd4, 0);
        drive(1, 3'd4, 0);
        drive(1, 3'd5, 0);
        chk("pattern_map", 32'(map[3:0]), 32'h6);
        chk("pattern_branches", 32'(branches), 32'd4);

        // Mid-operation reset at count 7
        drive(1, 3'd4, 0);
        drive(1, 3'd5, 0);
        drive(1, 3'd4, 0);
        chk("pre_reset_branches", 32'(branches), 32'd7);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_map", 32'(map), 32'h0);
        chk("midreset_branches", 32'(branches), 32'h0);
        chk("midreset_empty", 32'(empty), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Filtering
        for (int t = 0; t < 8; t++) begin
            if (t != 4 && t != 5) drive(1, 3'(t), 0);
        end
        drive(0, 3'd4, 0);
        drive(0, 3'd5, 0);
        chk("filter_branches", 32'(branches), 32'd0);

        // Flush with event at count 10
        for (int i = 0; i < 10; i++) drive(1, (i % 3 == 0) ? 3'd4 : 3'd5, 0);
        chk("pre_flush_branches", 32'(branches), 32'd10);
        drive(1, 3'd5, 1);
        chk("flushev_branches", 32'(branches), 32'd1);
        chk("flushev_map", 32'(map), 32'h0);
        drive(0, 3'd0, 1);
        chk("flush_branches", 32'(branches), 32'd0);

        // Fill and overflow
        for (int i = 0; i < NB; i++) drive(1, 3'd4, 0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_map", 32'(map), 32'h7FFF_FFFF);
        drive(1, 3'd5, 0);
        chk("drop_map", 32'(map), 32'h7FFF_FFFF);
        chk("drop_branches", 32'(branches), 32'd31);
`ifdef TE_BRANCH_MAP_OVERFLOW_EN
        chk("drop_overflow", 32'(overflow), 32'd1);
`endif
        // Full with flush and event restarts at count 1
        drive(1, 3'd4, 1);
        chk("fullflush_branches", 32'(branches), 32'd1);
        chk("fullflush_map", 32'(map), 32'h1);
`ifdef TE_BRANCH_MAP_OVERFLOW_EN
        chk("sticky_overflow", 32'(overflow), 32'd1);
`endif

        // Mixed random traffic
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 19) == 0));
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
